// File: rtl/intrusion_guard_pkg.sv
// Shared state encodings and default 100 MHz timing for the guard and the downstream alarm stage.
// Anything that counts wall-clock time derives from CLK_HZ so both blocks agree on the clock rate.
package intrusion_guard_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

  localparam int unsigned CLK_HZ            = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC  = CLK_HZ / 100;
  localparam int unsigned DEF_EXIT_DLY_CYC  = CLK_HZ * 15;
  localparam int unsigned DEF_ENTRY_DLY_CYC = CLK_HZ * 10;
  localparam int unsigned DEF_MAX_FAILS     = 3;

  localparam logic [3:0] FAIL_SAT = 4'hF;

  function automatic logic [3:0] fail_inc(input logic [3:0] cnt);
    return (cnt == FAIL_SAT) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/intrusion_guard_debounce_sync.sv
// Two-flop synchroniser followed by a stability debouncer for the raw intrusion sensor.
// A clean input edge reaches dout DEBOUNCE_CYC+2 clocks later; shorter glitches never reach it.
module debounce_sync
  import intrusion_guard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned      CW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the held level restarts the stability window.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign dout = r_db;

endmodule

// File: rtl/intrusion_guard.sv
// Arm / exit-delay / armed / entry-delay / alarm controller with failed-code lockout.
// Outputs are registered from the next state, so they track the state register with no extra lag.
module intrusion_guard
  import intrusion_guard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int unsigned EXIT_DLY_CYC  = DEF_EXIT_DLY_CYC,
  parameter int unsigned ENTRY_DLY_CYC = DEF_ENTRY_DLY_CYC,
  parameter int unsigned MAX_FAILS     = DEF_MAX_FAILS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  input  logic       arm_req,
  input  logic       code_valid,
  input  logic       code_ok,
  output logic       alarm_req,
  output logic       armed,
  output logic       pending,
  output logic [2:0] state_o,
  output logic [3:0] fail_cnt_o
);

  localparam logic [3:0]  MAX_F      = 4'(MAX_FAILS);
  localparam logic [31:0] EXIT_LOAD  = 32'(EXIT_DLY_CYC - 1);
  localparam logic [31:0] ENTRY_LOAD = 32'(ENTRY_DLY_CYC - 1);

  logic        w_sensor_db;
  logic        w_good;
  logic        w_bad;
  logic        w_expired;
  logic        w_limit;
  logic [3:0]  w_fail_inc;
  state_t      w_nxt;
  logic [3:0]  w_nxt_fail;

  state_t      r_state;
  logic [3:0]  r_fail;
  logic [31:0] r_dly;
  logic        r_alarm;
  logic        r_armed;
  logic        r_pending;

  debounce_sync #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (sensor_in),
    .dout(w_sensor_db)
  );

  assign w_good     = code_valid & code_ok;
  assign w_bad      = code_valid & ~code_ok;
  assign w_expired  = (r_dly == 32'd0);
  assign w_fail_inc = fail_inc(r_fail);
  assign w_limit    = w_bad & (w_fail_inc == MAX_F);

  // Priority within a cycle: good code, then fail limit, then delay expiry, then sensor.
  always_comb begin
    w_nxt      = r_state;
    w_nxt_fail = r_fail;
    case (r_state)
      ST_DISARMED: begin
        if (arm_req) w_nxt = ST_EXIT_DELAY;
      end
      ST_EXIT_DELAY: begin
        if (w_good)         w_nxt = ST_DISARMED;
        else if (w_expired) w_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_good) begin
          w_nxt = ST_DISARMED;
        end else begin
          if (w_bad) w_nxt_fail = w_fail_inc;
          if (w_limit)          w_nxt = ST_ALARM;
          else if (w_sensor_db) w_nxt = ST_ENTRY_DELAY;
        end
      end
      ST_ENTRY_DELAY: begin
        if (w_good) begin
          w_nxt = ST_DISARMED;
        end else begin
          if (w_bad) w_nxt_fail = w_fail_inc;
          if (w_limit || w_expired) w_nxt = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (w_good)     w_nxt = ST_DISARMED;
        else if (w_bad) w_nxt_fail = w_fail_inc;
      end
      default: w_nxt = ST_DISARMED;
    endcase
    if (w_nxt == ST_DISARMED) w_nxt_fail = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_DISARMED;
      r_fail    <= '0;
      r_dly     <= '0;
      r_alarm   <= 1'b0;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_fail  <= w_nxt_fail;
      // Loaded with DLY-1 so expiry, taken when the counter reads zero, lands on cycle DLY.
      if (w_nxt == ST_EXIT_DELAY && r_state != ST_EXIT_DELAY)
        r_dly <= EXIT_LOAD;
      else if (w_nxt == ST_ENTRY_DELAY && r_state != ST_ENTRY_DELAY)
        r_dly <= ENTRY_LOAD;
      else if (!w_expired)
        r_dly <= r_dly - 32'd1;
      r_alarm   <= (w_nxt == ST_ALARM);
      r_armed   <= (w_nxt == ST_ARMED) || (w_nxt == ST_ENTRY_DELAY);
      r_pending <= (w_nxt == ST_EXIT_DELAY) || (w_nxt == ST_ENTRY_DELAY);
    end
  end

  assign alarm_req  = r_alarm;
  assign armed      = r_armed;
  assign pending    = r_pending;
  assign state_o    = r_state;
  assign fail_cnt_o = r_fail;

endmodule

// File: tb/tb_intrusion_guard.sv
// Randomised and scenario stimulus against a cycle-level behavioural model; a monitor
// pops one expected output set per clock from the scoreboard queue.
module tb_intrusion_guard;

  localparam int DB  = 4;
  localparam int EXD = 10;
  localparam int ENT = 8;
  localparam int MF  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_in = 1'b0;
  logic       arm_req = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ok = 1'b0;
  logic       alarm_req;
  logic       armed;
  logic       pending;
  logic [2:0] state_o;
  logic [3:0] fail_cnt_o;

  intrusion_guard #(
    .DEBOUNCE_CYC (DB),
    .EXIT_DLY_CYC (EXD),
    .ENTRY_DLY_CYC(ENT),
    .MAX_FAILS    (MF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor_in (sensor_in),
    .arm_req   (arm_req),
    .code_valid(code_valid),
    .code_ok   (code_ok),
    .alarm_req (alarm_req),
    .armed     (armed),
    .pending   (pending),
    .state_o   (state_o),
    .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int fc;
    bit al;
    bit ar;
    bit pe;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: state names as plain numbers, time spent in the current state, and the
  // synchronised sensor history with a run length of samples disagreeing with sensor_db.
  int m_st, m_fc, m_el, m_run;
  bit m_db, m_p1, m_p2;
  bit cur_s;

  function automatic void model_reset();
    m_st = 0; m_fc = 0; m_el = 0; m_run = 0;
    m_db = 0; m_p1 = 0; m_p2 = 0;
  endfunction

  task automatic model_step(input bit s, input bit a, input bit cv, input bit ok);
    bit good, bad;
    int nst, nfc;
    good = cv && ok;
    bad  = cv && !ok;
    nst  = m_st;
    nfc  = m_fc;
    case (m_st)
      0: if (a) nst = 1;
      1: if (good) nst = 0; else if (m_el == EXD - 1) nst = 2;
      2: if (good) nst = 0;
         else begin
           if (bad) nfc = m_fc + 1;
           if (bad && nfc == MF) nst = 4;
           else if (m_db) nst = 3;
         end
      3: if (good) nst = 0;
         else begin
           if (bad) nfc = m_fc + 1;
           if ((bad && nfc == MF) || m_el == ENT - 1) nst = 4;
         end
      4: if (good) nst = 0; else if (bad) nfc = (m_fc < 15) ? m_fc + 1 : 15;
      default: nst = 0;
    endcase
    if (nst == 0) nfc = 0;
    m_el = (nst != m_st) ? 0 : m_el + 1;
    m_st = nst;
    m_fc = nfc;
    if (m_p2 != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = m_p2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_p2 = m_p1;
    m_p1 = s;
  endtask

  task automatic cycle(input bit s, input bit a, input bit cv, input bit ok);
    exp_t e;
    @(negedge clk);
    sensor_in = s; arm_req = a; code_valid = cv; code_ok = ok;
    cur_s = s;
    model_step(s, a, cv, ok);
    e.st = m_st;
    e.fc = m_fc;
    e.al = (m_st == 4);
    e.ar = (m_st == 2) || (m_st == 3);
    e.pe = (m_st == 1) || (m_st == 3);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic idle_until(input int st, input int lim, input bit s, input string nm);
    int n;
    n = 0;
    while (m_st != st && n < lim) begin
      cycle(s, 0, 0, 0);
      n++;
    end
    chk(nm, int'(state_o), st);
  endtask

  task automatic run_to_entry_expiry(input string nm);
    int n;
    n = 0;
    while (!(m_st == 3 && m_el == ENT - 1) && n < 40) begin
      cycle(1, 0, 0, 0);
      n++;
    end
    chk(nm, int'(state_o), 3);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("async rst alarm_req", int'(alarm_req), 0);
    chk("async rst state_o", int'(state_o), 0);
    chk("async rst fail_cnt_o", int'(fail_cnt_o), 0);
    sensor_in = 0; arm_req = 0; code_valid = 0; code_ok = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (state_o !== 3'(e.st) || fail_cnt_o !== 4'(e.fc) || alarm_req !== e.al ||
            armed !== e.ar || pending !== e.pe) begin
          n_err++;
          $display("FAIL scoreboard t=%0t: got st=%0d fc=%0d al=%0b ar=%0b pe=%0b, need st=%0d fc=%0d al=%0b ar=%0b pe=%0b",
                   $time, state_o, fail_cnt_o, alarm_req, armed, pending, e.st, e.fc, e.al, e.ar, e.pe);
        end
      end
    end
  end

  initial begin : stim
    model_reset();
    cur_s = 0;
    #1;
    chk("reset state_o", int'(state_o), 0);
    chk("reset alarm_req", int'(alarm_req), 0);
    chk("reset armed", int'(armed), 0);
    chk("reset pending", int'(pending), 0);
    chk("reset fail_cnt_o", int'(fail_cnt_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Arm cycle: ten cycles of exit delay, then armed.
    cycle(0, 1, 0, 0);
    chk("exit pending", int'(pending), 1);
    repeat (9) cycle(0, 0, 0, 0);
    chk("exit last cycle", int'(state_o), 1);
    cycle(0, 0, 0, 0);
    chk("armed state", int'(state_o), 2);
    chk("armed flag", int'(armed), 1);
    chk("armed pending", int'(pending), 0);
    chk("armed alarm_req", int'(alarm_req), 0);

    // Intrusion then entry timeout.
    repeat (6) cycle(1, 0, 0, 0);
    chk("sensor before db", int'(state_o), 2);
    cycle(1, 0, 0, 0);
    chk("entry start", int'(state_o), 3);
    repeat (7) cycle(1, 0, 0, 0);
    chk("entry last cycle", int'(state_o), 3);
    cycle(1, 0, 0, 0);
    chk("timeout state", int'(state_o), 4);
    chk("timeout alarm_req", int'(alarm_req), 1);
    cycle(0, 0, 1, 1);
    chk("disarm state", int'(state_o), 0);
    chk("disarm alarm_req", int'(alarm_req), 0);
    chk("disarm fail_cnt", int'(fail_cnt_o), 0);

    // Glitch filter.
    repeat (8) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    chk("glitch armed", int'(state_o), 2);
    repeat (3) cycle(1, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0);
    chk("glitch filtered", int'(state_o), 2);
    repeat (4) cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    chk("4-cycle pulse trips", int'(state_o), 3);

    // Lockout from entry delay.
    cycle(0, 0, 1, 0);
    chk("lockout fail 1", int'(fail_cnt_o), 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("lockout fail 2", int'(fail_cnt_o), 2);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("lockout fail 3", int'(fail_cnt_o), 3);
    chk("lockout alarm", int'(state_o), 4);
    repeat (14) cycle(0, 0, 1, 0);
    chk("fail saturation", int'(fail_cnt_o), 15);
    cycle(0, 0, 1, 1);
    chk("lockout disarm", int'(state_o), 0);

    // Good code on the entry expiry cycle.
    repeat (8) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle_until(2, 20, 0, "reach armed");
    run_to_entry_expiry("reach expiry good");
    cycle(1, 0, 1, 1);
    chk("good on expiry", int'(state_o), 0);

    // Sensor still active at arming trips straight into entry; bad code on expiry.
    cycle(1, 1, 0, 0);
    repeat (10) cycle(1, 0, 0, 0);
    chk("armed with sensor", int'(state_o), 2);
    cycle(1, 0, 0, 0);
    chk("immediate trip", int'(state_o), 3);
    run_to_entry_expiry("reach expiry bad");
    cycle(1, 0, 1, 0);
    chk("bad on expiry state", int'(state_o), 4);
    chk("bad on expiry fail", int'(fail_cnt_o), 1);
    cycle(0, 0, 1, 1);

    // Reset in the middle of an alarm.
    cycle(1, 1, 0, 0);
    idle_until(4, 40, 1, "reach alarm");
    do_reset();
    cycle(0, 1, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    chk("rearm after reset", int'(state_o), 2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5, 0) == 0) cur_s = ~cur_s;
      if ($urandom_range(599, 0) == 0) do_reset();
      cycle(cur_s, $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1);
    end

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
